gf180mcu_fd_sc_mcu9t5v0__dffq_pipe: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dffq_pipe

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffq_pipe.sv | 105 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffq_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffq_pipe.sv
// Enabled register pipeline with per-stage valid, data gating, flush and occupancy count.
// Optional scan chain: define GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN.

module gf180mcu_fd_sc_mcu9t5v0__dffq_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
  input  logic             se,
  input  logic             si,
`endif
  input  logic             en,
  input  logic             flush,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] dq
);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      dq <= '0;
      v  <= 1'b0;
    end
`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
    // chain order inside a stage: si -> dq[0] .. dq[WIDTH-1] -> v
    else if (se) begin
      {v, dq} <= {dq, si};
    end
`endif
    else if (flush) begin
      v <= 1'b0;
    end else if (en) begin
      v <= src_v;
      if (src_v) dq <= src_d;
    end
  end

endmodule

module gf180mcu_fd_sc_mcu9t5v0__dffq_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       CLK,
  input  logic                       RN,
`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
  input  logic                       SE,
  input  logic                       SI,
  output logic                       SO,
`endif
  input  logic [WIDTH-1:0]           D,
  input  logic                       VLD_IN,
  input  logic                       EN,
  input  logic                       FLUSH,
  output logic [WIDTH-1:0]           Q,
  output logic                       VLD_OUT,
  output logic [$clog2(DEPTH+1)-1:0] CNT
);

  localparam int CW = $clog2(DEPTH+1);

  // index 0 is the pipe input, index k+1 is the output of stage k
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;

  assign vld_pipe[0] = VLD_IN;
  assign dat_pipe[0] = D;

`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
  logic [DEPTH-1:0] scan_in;

  always_comb begin
    scan_in    = vld_pipe[DEPTH-1:0];
    scan_in[0] = SI;
  end

  assign SO = vld_pipe[DEPTH];
`endif

  gf180mcu_fd_sc_mcu9t5v0__dffq_pipe_stage #(.WIDTH(WIDTH)) u_stage [DEPTH-1:0] (
    .CLK   (CLK),
    .RN    (RN),
`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
    .se    (SE),
    .si    (scan_in),
`endif
    .en    (EN),
    .flush (FLUSH),
    .src_v (vld_pipe[DEPTH-1:0]),
    .src_d (dat_pipe[DEPTH-1:0]),
    .v     (vld_pipe[DEPTH:1]),
    .dq    (dat_pipe[DEPTH:1])
  );

  assign Q       = dat_pipe[DEPTH];
  assign VLD_OUT = vld_pipe[DEPTH];

  always_comb begin
    CNT = '0;
    for (int k = 1; k <= DEPTH; k++) CNT = CNT + CW'(vld_pipe[k]);
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffq_pipe.sv
// Bench for the gated register pipeline: directed scenarios plus random traffic vs a token-queue model.
// Scan scenario is built when GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN is defined.

module tb_gf180mcu_fd_sc_mcu9t5v0__dffq_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             CLK = 1'b0;
  logic             RN = 1'b1;
  logic [WIDTH-1:0] D = '0;
  logic             VLD_IN = 1'b0;
  logic             EN = 1'b0;
  logic             FLUSH = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             VLD_OUT;
  logic [1:0]       CNT;
`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
  logic SE = 1'b0;
  logic SI = 1'b0;
  logic SO;
`endif

  int total = 0;
  int bad = 0;

  gf180mcu_fd_sc_mcu9t5v0__dffq_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RN      (RN),
`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
    .SE      (SE),
    .SI      (SI),
    .SO      (SO),
`endif
    .D       (D),
    .VLD_IN  (VLD_IN),
    .EN      (EN),
    .FLUSH   (FLUSH),
    .Q       (Q),
    .VLD_OUT (VLD_OUT),
    .CNT     (CNT)
  );

  always #5 CLK = ~CLK;

  // Model: queue of tokens in flight (front = newest); Q is the last valid token to reach the end.
  typedef struct packed { logic v; logic [WIDTH-1:0] d; } tok_t;
  tok_t             pipe[$];
  logic [WIDTH-1:0] q_m;

  function automatic void model_reset();
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back('0);
    q_m = '0;
  endfunction

  function automatic void model_edge(logic en, logic vin, logic fl, logic [WIDTH-1:0] d);
    tok_t t;
    if (fl) begin
      foreach (pipe[k]) pipe[k].v = 1'b0;
    end else if (en) begin
      t.v = vin;
      t.d = d;
      pipe.push_front(t);
      void'(pipe.pop_back());
      if (pipe[DEPTH-1].v) q_m = pipe[DEPTH-1].d;
    end
  endfunction

  function automatic int m_cnt();
    int n = 0;
    foreach (pipe[k]) n += int'(pipe[k].v);
    return n;
  endfunction

  task automatic tick(input logic en, input logic vin, input logic fl, input logic [WIDTH-1:0] d);
    EN = en; VLD_IN = vin; FLUSH = fl; D = d;
    @(posedge CLK);
    model_edge(en, vin, fl, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RN = 1'b0;
    EN = 1'b0; VLD_IN = 1'b0; FLUSH = 1'b0;
    @(negedge CLK);
    RN = 1'b1;
    model_reset();
  endtask

  task automatic fill3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    tick(1'b1, 1'b1, 1'b0, a);
    tick(1'b1, 1'b1, 1'b0, b);
    tick(1'b1, 1'b1, 1'b0, c);
  endtask

  task automatic test_reset();
    #2 RN = 1'b0;
    #1;
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", Q); end
    total++; if (VLD_OUT !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", VLD_OUT); end
    total++; if (CNT !== 2'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", CNT); end
    EN = 1'b1; VLD_IN = 1'b1; D = 8'h5A;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (CNT !== 2'd0 || VLD_OUT !== 1'b0 || Q !== 8'h00) begin
      bad++; $display("FAIL reset_hold: got cnt=%0d vld=%b q=%h want 0/0/00", CNT, VLD_OUT, Q);
    end
    @(negedge CLK);
    EN = 1'b0; VLD_IN = 1'b0;
    RN = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 8'h11);
    total++; if (CNT !== 2'd1) begin bad++; $display("FAIL fill_cnt1: got %0d want 1", CNT); end
    tick(1'b1, 1'b1, 1'b0, 8'h22);
    total++; if (VLD_OUT !== 1'b0) begin bad++; $display("FAIL fill_early_vld: got %b want 0", VLD_OUT); end
    tick(1'b1, 1'b1, 1'b0, 8'h33);
    total++; if (Q !== 8'h11 || VLD_OUT !== 1'b1) begin
      bad++; $display("FAIL fill_e3: got q=%h vld=%b want 11/1", Q, VLD_OUT);
    end
    total++; if (CNT !== 2'd3) begin bad++; $display("FAIL fill_cnt3: got %0d want 3", CNT); end
    tick(1'b1, 1'b1, 1'b0, 8'h44);
    total++; if (Q !== 8'h22) begin bad++; $display("FAIL fill_e4: got %h want 22", Q); end
  endtask

  task automatic test_bubble();
    logic [1:0] exp_cnt[4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic       exp_vld[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, i == 0, 1'b0, (i == 0) ? 8'hA5 : 8'(i));
      total++; if (CNT !== exp_cnt[i] || VLD_OUT !== exp_vld[i]) begin
        bad++; $display("FAIL bubble_%0d: got cnt=%0d vld=%b want %0d/%b", i, CNT, VLD_OUT, exp_cnt[i], exp_vld[i]);
      end
    end
    total++; if (Q !== 8'hA5) begin bad++; $display("FAIL bubble_hold_q: got %h want a5", Q); end
  endtask

  task automatic test_stall();
    do_reset();
    fill3(8'h01, 8'h02, 8'h03);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'($urandom));
      total++; if (Q !== 8'h01 || VLD_OUT !== 1'b1 || CNT !== 2'd3) begin
        bad++; $display("FAIL stall_%0d: got q=%h vld=%b cnt=%0d want 01/1/3", i, Q, VLD_OUT, CNT);
      end
    end
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (Q !== 8'h02 || VLD_OUT !== 1'b1) begin bad++; $display("FAIL stall_resume2: got q=%h vld=%b want 02/1", Q, VLD_OUT); end
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (Q !== 8'h03 || VLD_OUT !== 1'b1) begin bad++; $display("FAIL stall_resume3: got q=%h vld=%b want 03/1", Q, VLD_OUT); end
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (Q !== 8'h03 || VLD_OUT !== 1'b0 || CNT !== 2'd0) begin
      bad++; $display("FAIL stall_drain: got q=%h vld=%b cnt=%0d want 03/0/0", Q, VLD_OUT, CNT);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill3(8'h01, 8'h02, 8'h03);
    tick(1'b1, 1'b1, 1'b1, 8'h77);
    total++; if (CNT !== 2'd0 || VLD_OUT !== 1'b0 || Q !== 8'h01) begin
      bad++; $display("FAIL flush: got cnt=%0d vld=%b q=%h want 0/0/01", CNT, VLD_OUT, Q);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (VLD_OUT !== 1'b0 || Q !== 8'h01) begin
        bad++; $display("FAIL flush_after_%0d: got vld=%b q=%h want 0/01", i, VLD_OUT, Q);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 8'hC1);
    tick(1'b1, 1'b1, 1'b0, 8'hC2);
    #2 RN = 1'b0;
    #1;
    total++; if (Q !== 8'h00 || VLD_OUT !== 1'b0 || CNT !== 2'd0) begin
      bad++; $display("FAIL async_reset: got q=%h vld=%b cnt=%0d want 00/0/0", Q, VLD_OUT, CNT);
    end
    EN = 1'b1; VLD_IN = 1'b1; D = 8'hEE;
    @(posedge CLK); #1;
    total++; if (CNT !== 2'd0) begin bad++; $display("FAIL async_reset_clk: got cnt=%0d want 0", CNT); end
    @(negedge CLK);
    RN = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (VLD_OUT !== 1'b0 || Q !== 8'h00) begin
        bad++; $display("FAIL async_reset_leak_%0d: got vld=%b q=%h want 0/00", i, VLD_OUT, Q);
      end
    end
  endtask

  task automatic test_random();
    logic en, vin, fl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(3) != 0);
      vin = $urandom_range(1);
      fl  = ($urandom_range(19) == 0);
      tick(en, vin, fl, 8'($urandom));
      total++; if (Q !== q_m) begin bad++; $display("FAIL rand_q_%0d: got %h want %h", i, Q, q_m); end
      total++; if (VLD_OUT !== pipe[DEPTH-1].v) begin
        bad++; $display("FAIL rand_vld_%0d: got %b want %b", i, VLD_OUT, pipe[DEPTH-1].v);
      end
      total++; if (CNT !== 2'(m_cnt())) begin bad++; $display("FAIL rand_cnt_%0d: got %0d want %0d", i, CNT, m_cnt()); end
    end
  endtask

`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
  task automatic test_scan();
    logic [26:0]      p;
    logic [26:0]      got;
    logic [WIDTH-1:0] exp_q;
    do_reset();
    p = 27'($urandom);
    SE = 1'b1;
    EN = 1'b0; FLUSH = 1'b1;
    // first bit shifted in travels furthest: bit t lands at chain position 26-t
    for (int t = 0; t < 27; t++) begin
      SI = p[t];
      @(posedge CLK); #1;
    end
    for (int i = 0; i < WIDTH; i++) exp_q[i] = p[8-i];
    total++; if (Q !== exp_q || VLD_OUT !== p[0]) begin
      bad++; $display("FAIL scan_load: got q=%h vld=%b want %h/%b", Q, VLD_OUT, exp_q, p[0]);
    end
    total++; if (CNT !== 2'(int'(p[0]) + int'(p[9]) + int'(p[18]))) begin
      bad++; $display("FAIL scan_cnt: got %0d want %0d", CNT, int'(p[0]) + int'(p[9]) + int'(p[18]));
    end
    for (int j = 0; j < 27; j++) begin
      got[j] = SO;
      SI = 1'b0;
      @(posedge CLK); #1;
    end
    total++; if (got !== p) begin bad++; $display("FAIL scan_unload: got %h want %h", got, p); end
    SE = 1'b0; FLUSH = 1'b0;
    model_reset();
    fill3(8'h3C, 8'h4D, 8'h5E);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (Q !== 8'h4D || VLD_OUT !== 1'b1 || CNT !== 2'd2) begin
      bad++; $display("FAIL scan_resume: got q=%h vld=%b cnt=%0d want 4d/1/2", Q, VLD_OUT, CNT);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_bubble();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
`ifdef GF180MCU_FD_SC_MCU9T5V0__DFFQ_PIPE_SCAN_EN
    test_scan();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
